pipe_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage integer pipeline. It drives the hold (enable-inverse) and flush (bubble-insert) controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC register. It arbitrates between data-bus wait, multi-cycle (mul/div) unit occupancy, taken branch/jump redirects and load-use hazards. It also provides a multi-cycle timeout watchdog and a saturating stall-cycle performance counter.

---
 rtl/pipe_ctrl.sv | 159 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: arbitrates data-bus wait,
// multi-cycle unit occupancy, redirects and load-use hazards.
module pipe_ctrl #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned MC_TIMEOUT = 64,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mem_wait,
   input  logic                  mc_start,
   input  logic                  mc_done,
   input  logic                  jump_req,
   input  logic [ADDR_WIDTH-1:0] jump_addr,
   input  logic                  ex_is_load,
   input  logic [4:0]            ex_rd,
   input  logic [4:0]            id_rs1,
   input  logic [4:0]            id_rs2,
   input  logic                  id_rs1_used,
   input  logic                  id_rs2_used,
   output logic                  hold_pc,
   output logic                  hold_if_id,
   output logic                  hold_id_ex,
   output logic                  hold_ex_mem,
   output logic                  hold_mem_wb,
   output logic                  flush_if_id,
   output logic                  flush_id_ex,
   output logic                  pc_load,
   output logic [ADDR_WIDTH-1:0] pc_load_addr,
   output logic                  mc_err,
   output logic [1:0]            busy_state,
   output logic [CNT_WIDTH-1:0]  stall_cnt
);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MC_WAIT = 2'd1,
      MC_ERR  = 2'd2
   } state_t;

   localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(MC_TIMEOUT - 1);

   state_t               state, state_nxt;
   logic [CNT_WIDTH-1:0] to_cnt, to_cnt_nxt;
   logic                 done_pend;
   logic                 done_seen;
   logic                 lu;

   assign lu = ex_is_load && (ex_rd != 5'd0) &&
               ((id_rs1_used && (id_rs1 == ex_rd)) ||
                (id_rs2_used && (id_rs2 == ex_rd)));

   // mc_done arriving while the bus stalls is remembered until the FSM may move
   assign done_seen = mc_done || done_pend;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         to_cnt    <= '0;
         done_pend <= 1'b0;
         mc_err    <= 1'b0;
      end else begin
         state  <= state_nxt;
         to_cnt <= to_cnt_nxt;
         mc_err <= (state_nxt == MC_ERR) && (state != MC_ERR);
         if (!mem_wait)
            done_pend <= 1'b0;
         else if (mc_done && (state == MC_WAIT))
            done_pend <= 1'b1;
      end
   end

   always_comb begin
      state_nxt  = state;
      to_cnt_nxt = to_cnt;
      if (!mem_wait) begin
         case (state)
            RUN: begin
               if (mc_start && !jump_req) begin
                  state_nxt  = MC_WAIT;
                  to_cnt_nxt = '0;
               end
            end
            MC_WAIT: begin
               if (done_seen)
                  state_nxt = RUN;
               else if (to_cnt == TO_LAST)
                  state_nxt = MC_ERR;
               else
                  to_cnt_nxt = to_cnt + 1'b1;
            end
            MC_ERR:  state_nxt = RUN;
            default: state_nxt = RUN;
         endcase
      end
   end

   always_comb begin
      hold_pc      = 1'b0;
      hold_if_id   = 1'b0;
      hold_id_ex   = 1'b0;
      hold_ex_mem  = 1'b0;
      hold_mem_wb  = 1'b0;
      flush_if_id  = 1'b0;
      flush_id_ex  = 1'b0;
      pc_load      = 1'b0;
      pc_load_addr = '0;
      if (rst_n) begin
         if (mem_wait) begin
            hold_pc     = 1'b1;
            hold_if_id  = 1'b1;
            hold_id_ex  = 1'b1;
            hold_ex_mem = 1'b1;
            hold_mem_wb = 1'b1;
         end else begin
            case (state)
               MC_WAIT: begin
                  hold_pc     = 1'b1;
                  hold_if_id  = 1'b1;
                  hold_id_ex  = 1'b1;
                  hold_ex_mem = 1'b1;
               end
               MC_ERR: begin
                  hold_pc     = 1'b1;
                  hold_if_id  = 1'b1;
                  flush_id_ex = 1'b1;
               end
               default: begin
                  if (jump_req) begin
                     pc_load      = 1'b1;
                     pc_load_addr = jump_addr;
                     flush_if_id  = 1'b1;
                     flush_id_ex  = 1'b1;
                  end else if (mc_start) begin
                     hold_pc     = 1'b1;
                     hold_if_id  = 1'b1;
                     hold_id_ex  = 1'b1;
                     hold_ex_mem = 1'b1;
                  end else if (lu) begin
                     hold_pc     = 1'b1;
                     hold_if_id  = 1'b1;
                     flush_id_ex = 1'b1;
                  end
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt <= '0;
      else if (hold_pc && (stall_cnt != '1))
         stall_cnt <= stall_cnt + 1'b1;
   end

   assign busy_state = state;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a default instance (a) and a short-timeout,
// narrow-counter instance (b) share one stimulus set.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_wait, mc_start, mc_done, jump_req;
   logic [31:0] jump_addr;
   logic        ex_is_load;
   logic [4:0]  ex_rd, id_rs1, id_rs2;
   logic        id_rs1_used, id_rs2_used;

   logic        hp_a, hif_a, hid_a, hex_a, hmw_a, fif_a, fid_a, pl_a, err_a;
   logic [31:0] pa_a;
   logic [1:0]  busy_a;
   logic [15:0] stall_a;
   logic        hp_b, hif_b, hid_b, hex_b, hmw_b, fif_b, fid_b, pl_b, err_b;
   logic [31:0] pa_b;
   logic [1:0]  busy_b;
   logic [3:0]  stall_b;

   logic [7:0]  ctl_a, ctl_b;
   assign ctl_a = {hp_a, hif_a, hid_a, hex_a, hmw_a, fif_a, fid_a, pl_a};
   assign ctl_b = {hp_b, hif_b, hid_b, hex_b, hmw_b, fif_b, fid_b, pl_b};

   localparam logic [7:0] C_NONE = 8'b00000_000;
   localparam logic [7:0] C_ALL  = 8'b11111_000;
   localparam logic [7:0] C_MC   = 8'b11110_000;
   localparam logic [7:0] C_LU   = 8'b11000_010;
   localparam logic [7:0] C_JMP  = 8'b00000_111;
   localparam logic [7:0] C_ERR  = 8'b11000_010;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   pipe_ctrl u_dut_a (
      .clk(clk), .rst_n(rst_n), .mem_wait(mem_wait), .mc_start(mc_start),
      .mc_done(mc_done), .jump_req(jump_req), .jump_addr(jump_addr),
      .ex_is_load(ex_is_load), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .hold_pc(hp_a), .hold_if_id(hif_a), .hold_id_ex(hid_a),
      .hold_ex_mem(hex_a), .hold_mem_wb(hmw_a), .flush_if_id(fif_a),
      .flush_id_ex(fid_a), .pc_load(pl_a), .pc_load_addr(pa_a),
      .mc_err(err_a), .busy_state(busy_a), .stall_cnt(stall_a)
   );

   pipe_ctrl #(.ADDR_WIDTH(32), .MC_TIMEOUT(8), .CNT_WIDTH(4)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .mem_wait(mem_wait), .mc_start(mc_start),
      .mc_done(mc_done), .jump_req(jump_req), .jump_addr(jump_addr),
      .ex_is_load(ex_is_load), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .hold_pc(hp_b), .hold_if_id(hif_b), .hold_id_ex(hid_b),
      .hold_ex_mem(hex_b), .hold_mem_wb(hmw_b), .flush_if_id(fif_b),
      .flush_id_ex(fid_b), .pc_load(pl_b), .pc_load_addr(pa_b),
      .mc_err(err_b), .busy_state(busy_b), .stall_cnt(stall_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      else
         n_pass++;
   endtask

   task automatic clear_inputs();
      mem_wait    = 1'b0;
      mc_start    = 1'b0;
      mc_done     = 1'b0;
      jump_req    = 1'b0;
      jump_addr   = '0;
      ex_is_load  = 1'b0;
      ex_rd       = '0;
      id_rs1      = '0;
      id_rs2      = '0;
      id_rs1_used = 1'b0;
      id_rs2_used = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_inputs();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic set_lu(input logic [4:0] rd);
      ex_is_load  = 1'b1;
      ex_rd       = rd;
      id_rs2      = rd;
      id_rs2_used = 1'b1;
   endtask

   task automatic mc_pulse();
      mc_start = 1'b1;
      mid();
      tick();
      mc_start = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      // reset with requests active: everything forced low
      clear_inputs();
      rst_n     = 1'b0;
      jump_req  = 1'b1;
      jump_addr = 32'h0000_0100;
      mc_start  = 1'b1;
      #2;
      check("rst_ctl", ctl_a, C_NONE);
      check("rst_addr", pa_a, 32'h0);
      check("rst_busy", busy_a, 2'd0);
      check("rst_stall", stall_a, 16'd0);
      check("rst_err", err_a, 1'b0);
      tick();
      rst_n = 1'b1;
      clear_inputs();

      for (int i = 0; i < 10; i++) begin
         mid();
         check("idle_ctl", ctl_a, C_NONE);
         tick();
      end
      check("idle_busy", busy_a, 2'd0);
      check("idle_stall", stall_a, 16'd0);

      // load-use through rs2
      set_lu(5'd5);
      mid();
      check("lu_ctl", ctl_a, C_LU);
      tick();
      clear_inputs();
      mid();
      check("lu_release", ctl_a, C_NONE);
      check("lu_stall", stall_a, 16'd1);
      tick();
      // x0 destination never stalls
      set_lu(5'd0);
      mid();
      check("lu_x0", ctl_a, C_NONE);
      tick();
      clear_inputs();
      // load-use through rs1, then a match on an unused source
      ex_is_load = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_rs1_used = 1'b1;
      mid();
      check("lu_rs1", ctl_a, C_LU);
      tick();
      id_rs1_used = 1'b0; id_rs2 = 5'd7;
      mid();
      check("lu_unused", ctl_a, C_NONE);
      tick();
      clear_inputs();
      mid();
      check("lu_stall2", stall_a, 16'd2);
      tick();

      // jump beats load-use
      set_lu(5'd5);
      jump_req  = 1'b1;
      jump_addr = 32'h0000_0100;
      mid();
      check("jmp_ctl", ctl_a, C_JMP);
      check("jmp_addr", pa_a, 32'h0000_0100);
      tick();
      clear_inputs();
      // jump with mc_start: mc_start ignored
      jump_req = 1'b1; jump_addr = 32'hDEAD_BEE0; mc_start = 1'b1;
      mid();
      check("jmp_mc_ctl", ctl_a, C_JMP);
      check("jmp_mc_addr", pa_a, 32'hDEAD_BEE0);
      tick();
      clear_inputs();
      mid();
      check("jmp_mc_busy", busy_a, 2'd0);
      check("jmp_stall", stall_a, 16'd2);
      tick();

      // multi-cycle op, done 33 cycles after start
      do_reset();
      mc_start = 1'b1;
      mid();
      check("mc_start_ctl", ctl_a, C_MC);
      tick();
      mc_start = 1'b0;
      for (int i = 1; i <= 33; i++) begin
         if (i == 33) mc_done = 1'b1;
         mid();
         check("mc_busy", busy_a, 2'd1);
         check("mc_ctl", ctl_a, C_MC);
         tick();
         mc_done = 1'b0;
      end
      mid();
      check("mc_end_busy", busy_a, 2'd0);
      check("mc_end_ctl", ctl_a, C_NONE);
      check("mc_end_stall", stall_a, 16'd34);
      tick();

      // timeout on the short instance
      do_reset();
      mc_pulse();
      for (int k = 1; k <= 8; k++) begin
         mid();
         check("to_wait_busy", busy_b, 2'd1);
         check("to_wait_err", err_b, 1'b0);
         tick();
      end
      mid();
      check("to_err_busy", busy_b, 2'd2);
      check("to_err_pulse", err_b, 1'b1);
      check("to_err_ctl", ctl_b, C_ERR);
      tick();
      mid();
      check("to_after_busy", busy_b, 2'd0);
      check("to_after_err", err_b, 1'b0);
      check("to_after_ctl", ctl_b, C_NONE);
      tick();

      // mc_done on the timeout edge wins
      do_reset();
      mc_pulse();
      for (int k = 1; k <= 8; k++) begin
         if (k == 8) mc_done = 1'b1;
         mid();
         tick();
         mc_done = 1'b0;
      end
      mid();
      check("coinc_busy", busy_b, 2'd0);
      check("coinc_err", err_b, 1'b0);
      tick();
      mid();
      check("coinc_err2", err_b, 1'b0);
      tick();

      // mem_wait freezes the timeout counter
      do_reset();
      mc_pulse();
      for (int k = 0; k < 3; k++) begin
         mid();
         check("frz_pre_busy", busy_b, 2'd1);
         tick();
      end
      mem_wait = 1'b1;
      for (int k = 0; k < 5; k++) begin
         mid();
         check("frz_ctl", ctl_b, C_ALL);
         check("frz_busy", busy_b, 2'd1);
         tick();
      end
      mem_wait = 1'b0;
      for (int k = 0; k < 5; k++) begin
         mid();
         check("frz_post_busy", busy_b, 2'd1);
         check("frz_post_ctl", ctl_b, C_MC);
         tick();
      end
      mid();
      check("frz_err_busy", busy_b, 2'd2);
      check("frz_stall", stall_b, 4'd14);
      tick();
      mid();
      check("frz_run_busy", busy_b, 2'd0);
      check("sat_stall15", stall_b, 4'd15);
      tick();
      set_lu(5'd3);
      tick();
      tick();
      clear_inputs();
      mid();
      check("sat_hold", stall_b, 4'd15);
      tick();

      // mc_done during mem_wait is remembered
      do_reset();
      mc_pulse();
      tick();
      tick();
      mem_wait = 1'b1;
      mc_done  = 1'b1;
      mid();
      tick();
      mc_done = 1'b0;
      for (int k = 0; k < 2; k++) begin
         mid();
         check("pend_busy", busy_a, 2'd1);
         tick();
      end
      mem_wait = 1'b0;
      mid();
      check("pend_last_ctl", ctl_a, C_MC);
      tick();
      mid();
      check("pend_run_busy", busy_a, 2'd0);
      check("pend_run_ctl", ctl_a, C_NONE);
      tick();

      // asynchronous reset mid-MC_WAIT
      do_reset();
      mc_pulse();
      tick();
      tick();
      mid();
      check("ar_pre_busy", busy_a, 2'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_ctl", ctl_a, C_NONE);
      check("ar_busy", busy_a, 2'd0);
      check("ar_stall", stall_a, 16'd0);
      check("ar_busy_b", busy_b, 2'd0);
      tick();
      rst_n = 1'b1;
      mid();
      check("ar_post_ctl", ctl_a, C_NONE);
      check("ar_post_busy", busy_a, 2'd0);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
